rd_return_bridge: RTL and testbench
===================================

Name: rd_return_bridge

Overview:
- Memory-stage read-return selector and M->W data register for the pipelined MIPS core.
- Chooses among three read-data sources:
  - CP0 read data, for mfc0.
  - One of NDEV memory-mapped peripherals, selected by address window.
  - Data memory output.
- Unlike the single-cycle selector, peripheral reads are multi-cycle: strobe/ack handshake, pipeline stall, timeout with bus error.

Parameters:
- NDEV, 2: number of peripheral channels (1..8).
- DEV_BASE, {28'h00007f1, 28'h00007f0}: packed NDEV×28-bit address prefixes; device i matches when addr[31:4] == DEV_BASE[28*i +: 28].
- TIMEOUT, 15: wait cycles allowed after the strobe before the access is aborted (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  M-stage instruction is a load or mfc0 needing read data.
- instr  in  32  M-stage instruction word.
- addr  in  32  M-stage effective address (ALU result).
- dm_rdata  in  32  data memory read data.
- cp0_rdata  in  32  CP0 read data.
- dev_rdata  in  32*NDEV  packed peripheral read data; device i at [32*i +: 32].
- dev_ack  in  NDEV  per-device read acknowledge.
- dev_rd  out  NDEV  per-device read strobe.
- stall  out  1  freeze F/D/E/M stages.
- rdata_w  out  32  registered read data for W stage.
- rdata_valid  out  1  rdata_w updated this cycle.
- bus_err  out  1  one-cycle pulse, peripheral access timed out.

Behaviour:
- Decode (combinational):
  - mfc0 = instr[31:21] == 11'b01000000000 && instr[10:0] == 0.
  - hit[i] = addr[31:4] == DEV_BASE[i].
  - Source priority: mfc0 > lowest-index hit > DM.
- Reset (reset == 0, async): state IDLE, cnt = 0, sel_idx = 0; rdata_w = 0, rdata_valid = 0, bus_err = 0. dev_rd and stall are 0 during reset.
- FSM has two states, IDLE and WAIT; cnt is 8-bit.
- IDLE, req_valid = 0: rdata_valid <= 0; rdata_w holds its value.
- IDLE, req_valid = 1, source is mfc0 or DM:
  - rdata_w <= cp0_rdata or dm_rdata; rdata_valid <= 1.
  - No stall. One cycle latency.
- IDLE, req_valid = 1, device k selected:
  - dev_rd[k] = 1 this cycle only (one-cycle strobe).
  - If dev_ack[k] = 1 in the same cycle: zero-wait completion. rdata_w <= dev_rdata[k]; rdata_valid <= 1; stall = 0.
  - Otherwise: stall = 1; sel_idx <= k; cnt <= 0; go to WAIT; rdata_valid <= 0.
- WAIT:
  - stall = 1 unless completing this cycle; dev_rd = 0.
  - If dev_ack[sel_idx] = 1: rdata_w <= dev_rdata[sel_idx]; rdata_valid <= 1; stall = 0; go to IDLE.
  - Else if cnt == TIMEOUT-1: rdata_w <= 0; rdata_valid <= 1; bus_err <= 1 for one cycle; stall = 0; go to IDLE.
  - Else cnt <= cnt + 1.
  - The total wait is therefore bounded at TIMEOUT cycles after the strobe cycle.
- stall is combinational; the M-stage inputs are stable while stall = 1.
- Acks from non-selected devices, and any ack while IDLE without a strobe, are ignored.
- After completion, the next request is accepted in the cycle directly after the completion cycle, so back-to-back device accesses work.
- Asserting reset during WAIT aborts the access immediately: no bus_err, no rdata_valid.

Decomposition:
- Shared package holds:
  - MFC0_OP = 11'b01000000000.
  - State encodings IDLE = 1'b0, WAIT = 1'b1.
  - Default device prefixes 28'h00007f0 and 28'h00007f1.
- One sub-module, rd_addr_decode: combinational mfc0/hit/priority encoder that outputs a source select and device index.

Test Plan:
- DM read: req_valid = 1, instr = lw, addr = 0x00001000, dm_rdata = 0xDEADBEEF -> no stall; next cycle rdata_w = 0xDEADBEEF, rdata_valid = 1.
- mfc0 priority: instr = 0x40046000, addr = 0x00007F04, cp0_rdata = 0x12345678 -> dev_rd = 0; next cycle rdata_w = 0x12345678.
- Zero-wait device: addr = 0x00007F14, dev_ack[1] = 1 in the strobe cycle, dev_rdata[1] = 0xA5A5A5A5 -> dev_rd = 2'b10 for one cycle, stall = 0; next cycle rdata_w = 0xA5A5A5A5.
- Three-wait device: addr = 0x00007F00, dev_ack[0] rises 3 cycles after the strobe -> stall high for exactly 3 cycles; rdata_w = dev_rdata[0]; rdata_valid pulses once.
- Timeout: device 0 never acks, TIMEOUT = 15 -> stall high for 15 cycles; then rdata_w = 0, rdata_valid = 1, bus_err = 1 for one cycle.
- Reset mid-WAIT: reset low 2 cycles after the strobe -> stall = 0, state IDLE, rdata_valid = 0, no bus_err; a subsequent DM read completes normally.

Source files
------------

// File: rtl/rd_return_bridge_pkg.sv
// Shared types and constants for the M-stage read-return bridge.
package rd_return_bridge_pkg;

  localparam logic [10:0] MFC0_OP = 11'b01000000000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_DM  = 2'd0,
    SRC_CP0 = 2'd1,
    SRC_DEV = 2'd2
  } src_e;

  localparam logic [27:0] DEV0_BASE     = 28'h00007f0;
  localparam logic [27:0] DEV1_BASE     = 28'h00007f1;
  localparam logic [55:0] DEV_BASE_DFLT = {DEV1_BASE, DEV0_BASE};

  // Width of a device index; at least one bit so single-device builds stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_addr_decode.sv
// Read-source decode: mfc0 beats any device window hit, lowest device index wins, else DM.
module rd_addr_decode
  import rd_return_bridge_pkg::*;
#(
  parameter int                    NDEV     = 2,
  parameter logic [28*NDEV-1:0]    DEV_BASE = DEV_BASE_DFLT,
  localparam int                   IW       = idx_w(NDEV)
) (
  input  logic [31:0]   instr_i,
  input  logic [31:0]   addr_i,
  output src_e          src_o,
  output logic [IW-1:0] idx_o
);

  logic [NDEV-1:0] hit;
  logic            mfc0;
  logic            unused_bits;

  for (genvar g = 0; g < NDEV; g++) begin : g_hit
    assign hit[g] = (addr_i[31:4] == DEV_BASE[28*g +: 28]);
  end

  assign mfc0        = (instr_i[31:21] == MFC0_OP) && (instr_i[10:0] == 11'd0);
  assign unused_bits = ^{instr_i[20:11], addr_i[3:0]};

  always_comb begin
    src_o = SRC_DM;
    idx_o = '0;
    // Scan downward so the lowest matching index is the one left standing.
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        src_o = SRC_DEV;
        idx_o = IW'(i);
      end
    end
    if (mfc0) begin
      src_o = SRC_CP0;
      idx_o = '0;
    end
  end

endmodule

// File: rtl/rd_return_bridge.sv
// M-stage read-return selector and M->W data register; peripheral reads use a
// strobe/ack handshake with a pipeline stall and a bounded-wait bus error.
module rd_return_bridge
  import rd_return_bridge_pkg::*;
#(
  parameter int                 NDEV     = 2,
  parameter logic [28*NDEV-1:0] DEV_BASE = DEV_BASE_DFLT,
  parameter int                 TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [31:0]          instr,
  input  logic [31:0]          addr,
  input  logic [31:0]          dm_rdata,
  input  logic [31:0]          cp0_rdata,
  input  logic [32*NDEV-1:0]   dev_rdata,
  input  logic [NDEV-1:0]      dev_ack,
  output logic [NDEV-1:0]      dev_rd,
  output logic                 stall,
  output logic [31:0]          rdata_w,
  output logic                 rdata_valid,
  output logic                 bus_err
);

  localparam int          IW       = idx_w(NDEV);
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [NDEV-1:0] rd_c;
  logic            stall_c;

  src_e            src;
  logic [IW-1:0]   idx;

  rd_addr_decode #(
    .NDEV     (NDEV),
    .DEV_BASE (DEV_BASE)
  ) u_dec (
    .instr_i (instr),
    .addr_i  (addr),
    .src_o   (src),
    .idx_o   (idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rd_c    = '0;
    stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          unique case (src)
            SRC_CP0: begin
              rdata_d = cp0_rdata;
              valid_d = 1'b1;
            end
            SRC_DEV: begin
              rd_c[idx] = 1'b1;
              if (dev_ack[idx]) begin
                rdata_d = dev_rdata[32*idx +: 32];
                valid_d = 1'b1;
              end else begin
                stall_c = 1'b1;
                sel_d   = idx;
                cnt_d   = '0;
                state_d = WAIT;
              end
            end
            default: begin
              rdata_d = dm_rdata;
              valid_d = 1'b1;
            end
          endcase
        end
      end
      WAIT: begin
        if (dev_ack[sel_q]) begin
          rdata_d = dev_rdata[32*sel_q +: 32];
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Abandoned access returns zero so W never sees stale data.
          rdata_d = '0;
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational handshake outputs are forced quiet while reset is held.
  assign dev_rd      = reset ? rd_c : '0;
  assign stall       = reset & stall_c;
  assign rdata_w     = rdata_q;
  assign rdata_valid = valid_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_rd_return_bridge.sv
// Directed bench for rd_return_bridge: single-cycle vector table plus wait/timeout/reset sequences.
module tb_rd_return_bridge;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] instr, addr, dm_rdata, cp0_rdata;
  logic [63:0] dev_rdata;
  logic [1:0]  dev_ack;
  logic [1:0]  dev_rd;
  logic        stall;
  logic [31:0] rdata_w;
  logic        rdata_valid;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] LW = 32'h8C880000;

  rd_return_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .instr       (instr),
    .addr        (addr),
    .dm_rdata    (dm_rdata),
    .cp0_rdata   (cp0_rdata),
    .dev_rdata   (dev_rdata),
    .dev_ack     (dev_ack),
    .dev_rd      (dev_rd),
    .stall       (stall),
    .rdata_w     (rdata_w),
    .rdata_valid (rdata_valid),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] dm;
    logic [31:0] cp0;
    logic [63:0] drd;
    logic [1:0]  ack;
    logic [1:0]  e_rd;
    logic        e_stall;
    logic [31:0] e_rdata;
    logic        e_valid;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks a device access from its strobe cycle to its completion cycle.
  task automatic run_dev(input int ack_at, output int stalls, output int strobes);
    bit done;
    stalls  = 0;
    strobes = 0;
    done    = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 1) dev_ack = 2'b10;
      if (c == 2) dev_ack = 2'b00;
      if (c == ack_at) dev_ack = 2'b01;
      #1;
      if (dev_rd != 2'b00) strobes++;
      if (!stall) begin
        done = 1;
        break;
      end
      stalls++;
      step();
    end
    if (!done) chk("wait_bound", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, sb;

    vt[0] = '{1'b1, LW,            32'h00001000, 32'hDEADBEEF, 32'h0,        64'h0,                    2'b00, 2'b00, 1'b0, 32'hDEADBEEF, 1'b1};
    vt[1] = '{1'b1, 32'h40046000,  32'h00007F04, 32'h0,        32'h12345678, 64'h0,                    2'b01, 2'b00, 1'b0, 32'h12345678, 1'b1};
    vt[2] = '{1'b1, LW,            32'h00007F14, 32'h0,        32'h0,        64'hA5A5A5A5_00000000,    2'b10, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b1};
    vt[3] = '{1'b0, LW,            32'h00001000, 32'h99999999, 32'h0,        64'h0,                    2'b00, 2'b00, 1'b0, 32'hA5A5A5A5, 1'b0};
    vt[4] = '{1'b1, LW,            32'h00007F08, 32'h0,        32'h0,        64'h11111111_22222222,    2'b11, 2'b01, 1'b0, 32'h22222222, 1'b1};
    vt[5] = '{1'b0, LW,            32'h00007F00, 32'h0,        32'h0,        64'h33333333_44444444,    2'b11, 2'b00, 1'b0, 32'h22222222, 1'b0};
    vt[6] = '{1'b1, 32'h40046001,  32'h00002000, 32'h0BADF00D, 32'h55555555, 64'h0,                    2'b00, 2'b00, 1'b0, 32'h0BADF00D, 1'b1};
    vt[7] = '{1'b1, LW,            32'h00007F20, 32'hCAFE0001, 32'h0,        64'hFFFFFFFF_FFFFFFFF,    2'b11, 2'b00, 1'b0, 32'hCAFE0001, 1'b1};
    vt[8] = '{1'b1, 32'h40046000,  32'h00007F10, 32'h77777777, 32'h0,        64'h66666666_66666666,    2'b11, 2'b00, 1'b0, 32'h00000000, 1'b1};

    reset     = 1'b0;
    req_valid = 1'b1;
    instr     = LW;
    addr      = 32'h00007F00;
    dm_rdata  = '0;
    cp0_rdata = '0;
    dev_rdata = '0;
    dev_ack   = '0;

    #12;
    chk("rst_dev_rd", dev_rd, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rdata", rdata_w, 0);
    chk("rst_valid", rdata_valid, 0);
    chk("rst_bus_err", bus_err, 0);

    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      req_valid = vt[i].rv;
      instr     = vt[i].instr;
      addr      = vt[i].addr;
      dm_rdata  = vt[i].dm;
      cp0_rdata = vt[i].cp0;
      dev_rdata = vt[i].drd;
      dev_ack   = vt[i].ack;
      #1;
      chk($sformatf("v%0d_dev_rd", i), dev_rd, vt[i].e_rd);
      chk($sformatf("v%0d_stall", i), stall, vt[i].e_stall);
      step();
      chk($sformatf("v%0d_rdata", i), rdata_w, vt[i].e_rdata);
      chk($sformatf("v%0d_valid", i), rdata_valid, vt[i].e_valid);
      chk($sformatf("v%0d_bus_err", i), bus_err, 0);
    end
    req_valid = 1'b0;
    dev_ack   = 2'b00;
    step();

    // Device 0 acks three cycles after the strobe; a device-1 ack in between is ignored.
    req_valid = 1'b1;
    instr     = LW;
    addr      = 32'h00007F00;
    dev_rdata = 64'h11111111_5555AAAA;
    dev_ack   = 2'b00;
    run_dev(3, st, sb);
    chk("w3_stall_cycles", st, 3);
    chk("w3_strobes", sb, 1);
    step();
    req_valid = 1'b0;
    dev_ack   = 2'b00;
    chk("w3_rdata", rdata_w, 32'h5555AAAA);
    chk("w3_valid", rdata_valid, 1);
    chk("w3_bus_err", bus_err, 0);
    step();
    chk("w3_valid_pulse", rdata_valid, 0);

    // Device 0 never acks: timeout, then a back-to-back zero-wait device-1 read.
    req_valid = 1'b1;
    addr      = 32'h00007F04;
    dev_rdata = 64'h77778888_12121212;
    run_dev(-1, st, sb);
    chk("to_stall_cycles", st, 15);
    chk("to_strobes", sb, 1);
    step();
    addr    = 32'h00007F14;
    dev_ack = 2'b10;
    chk("to_rdata", rdata_w, 0);
    chk("to_valid", rdata_valid, 1);
    chk("to_bus_err", bus_err, 1);
    #1;
    chk("b2b_dev_rd", dev_rd, 2'b10);
    chk("b2b_stall", stall, 0);
    step();
    req_valid = 1'b0;
    dev_ack   = 2'b00;
    chk("b2b_rdata", rdata_w, 32'h77778888);
    chk("b2b_valid", rdata_valid, 1);
    chk("b2b_bus_err_pulse", bus_err, 0);
    step();

    // Reset two cycles after the strobe aborts the access silently.
    req_valid = 1'b1;
    addr      = 32'h00007F00;
    #1;
    chk("rw_strobe_stall", stall, 1);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rw_stall", stall, 0);
    chk("rw_dev_rd", dev_rd, 0);
    chk("rw_valid", rdata_valid, 0);
    chk("rw_bus_err", bus_err, 0);
    chk("rw_rdata", rdata_w, 0);
    step();
    chk("rw_hold_bus_err", bus_err, 0);
    req_valid = 1'b0;
    reset     = 1'b1;
    step();
    chk("rw_post_valid", rdata_valid, 0);
    chk("rw_post_bus_err", bus_err, 0);
    req_valid = 1'b1;
    instr     = LW;
    addr      = 32'h00001000;
    dm_rdata  = 32'h0F0F0F0F;
    #1;
    chk("rw_dm_stall", stall, 0);
    step();
    req_valid = 1'b0;
    chk("rw_dm_rdata", rdata_w, 32'h0F0F0F0F);
    chk("rw_dm_valid", rdata_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
